// File: rtl/picobello_dummy_tile_pkg.sv
// Shared types and widths for the picobello dummy (DECERR) tile.
package picobello_dummy_tile_pkg;

    localparam int unsigned AxiAddrWidth     = 48;
    localparam int unsigned AxiDataWidth     = 64;
    localparam int unsigned AxiIdWidth       = 4;
    localparam int unsigned DummyErrCntWidth = 32;
    localparam int unsigned CoordWidth       = 4;
    localparam int unsigned RespWidth        = 2;
    localparam int unsigned LenWidth         = 8;

    localparam logic [RespWidth-1:0] RespDecErr = 2'b11;

    typedef struct packed {
        logic [CoordWidth-1:0] x;
        logic [CoordWidth-1:0] y;
    } id_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DRAIN,
        W_RESP
    } dummy_w_state_e;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } dummy_r_state_e;

endpackage

// File: rtl/picobello_dummy_tile.sv
// AXI slave that terminates every write and read with DECERR.
// Optional error logging is enabled with `define PB_DUMMY_ERR_LOG_EN.
module picobello_dummy_tile
    import picobello_dummy_tile_pkg::*;
#(
    parameter int unsigned AddrWidth = AxiAddrWidth,
    parameter int unsigned DataWidth = AxiDataWidth,
    parameter int unsigned IdWidth   = AxiIdWidth,
    parameter int unsigned CntWidth  = DummyErrCntWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  id_t                  id_i,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic                 w_last_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [RespWidth-1:0] b_resp_o,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [LenWidth-1:0]  ar_len_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [RespWidth-1:0] r_resp_o,
    output logic                 r_last_o,
    output logic [CntWidth-1:0]  err_cnt_o,
    output logic [AddrWidth-1:0] err_addr_o
);

    dummy_w_state_e       w_state_q, w_state_d;
    dummy_r_state_e       r_state_q, r_state_d;
    logic                 aw_ready_q, aw_ready_d;
    logic                 w_ready_q, w_ready_d;
    logic                 b_valid_q, b_valid_d;
    logic [IdWidth-1:0]   b_id_q, b_id_d;
    logic                 ar_ready_q, ar_ready_d;
    logic                 r_valid_q, r_valid_d;
    logic                 r_last_q, r_last_d;
    logic [IdWidth-1:0]   r_id_q, r_id_d;
    logic [LenWidth-1:0]  r_cnt_q, r_cnt_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // Handshakes qualify on the registered ready/valid outputs the master sees.
    assign aw_hs = aw_valid_i & aw_ready_q;
    assign w_hs  = w_valid_i  & w_ready_q;
    assign b_hs  = b_valid_q  & b_ready_i;
    assign ar_hs = ar_valid_i & ar_ready_q;
    assign r_hs  = r_valid_q  & r_ready_i;

    // Write path: accept AW, swallow the W burst, return one DECERR B.
    always_comb begin
        w_state_d = w_state_q;
        b_id_d    = b_id_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    w_state_d = W_DRAIN;
                    b_id_d    = aw_id_i;
                end
            end
            W_DRAIN: begin
                if (w_hs && w_last_i) w_state_d = W_RESP;
            end
            W_RESP: begin
                if (b_hs) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
        aw_ready_d = (w_state_d == W_IDLE);
        w_ready_d  = (w_state_d == W_DRAIN);
        b_valid_d  = (w_state_d == W_RESP);
    end

    // Read path: accept AR, then emit len+1 zero-data DECERR beats.
    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_cnt_d   = r_cnt_q;
        r_last_d  = r_last_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_BURST;
                    r_id_d    = ar_id_i;
                    r_cnt_d   = ar_len_i;
                    r_last_d  = (ar_len_i == '0);
                end
            end
            R_BURST: begin
                if (r_hs) begin
                    if (r_cnt_q == '0) begin
                        r_state_d = R_IDLE;
                        r_last_d  = 1'b0;
                    end else begin
                        r_cnt_d  = r_cnt_q - LenWidth'(1);
                        r_last_d = (r_cnt_q == LenWidth'(1));
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        ar_ready_d = (r_state_d == R_IDLE);
        r_valid_d  = (r_state_d == R_BURST);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q  <= W_IDLE;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_id_q     <= '0;
            r_state_q  <= R_IDLE;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_id_q     <= '0;
            r_cnt_q    <= '0;
        end else begin
            w_state_q  <= w_state_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            b_id_q     <= b_id_d;
            r_state_q  <= r_state_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_last_q   <= r_last_d;
            r_id_q     <= r_id_d;
            r_cnt_q    <= r_cnt_d;
        end
    end

    assign aw_ready_o = aw_ready_q;
    assign w_ready_o  = w_ready_q;
    assign b_valid_o  = b_valid_q;
    assign b_id_o     = b_id_q;
    assign b_resp_o   = RespDecErr;
    assign ar_ready_o = ar_ready_q;
    assign r_valid_o  = r_valid_q;
    assign r_id_o     = r_id_q;
    assign r_data_o   = '0;
    assign r_resp_o   = RespDecErr;
    assign r_last_o   = r_last_q;

`ifdef PB_DUMMY_ERR_LOG_EN
    logic [CntWidth-1:0]  err_cnt_q, err_cnt_d;
    logic [AddrWidth-1:0] err_addr_q, err_addr_d;
    logic [CntWidth:0]    err_sum;

    // Saturating count of terminated transactions; AW address wins a tie.
    always_comb begin
        err_sum    = {1'b0, err_cnt_q} + (CntWidth+1)'(aw_hs) + (CntWidth+1)'(ar_hs);
        err_cnt_d  = err_sum[CntWidth] ? '1 : err_sum[CntWidth-1:0];
        err_addr_d = err_addr_q;
        if (ar_hs) err_addr_d = ar_addr_i;
        if (aw_hs) err_addr_d = aw_addr_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err_cnt_o  = err_cnt_q;
    assign err_addr_o = err_addr_q;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni && aw_hs)
            $warning("dummy tile (%0d,%0d): stray write to 0x%0h", id_i.x, id_i.y, aw_addr_i);
        if (rst_ni && ar_hs)
            $warning("dummy tile (%0d,%0d): stray read from 0x%0h", id_i.x, id_i.y, ar_addr_i);
    end
`endif
`else
    logic unused_log;
    assign unused_log = ^{id_i, aw_addr_i, ar_addr_i};
    assign err_cnt_o  = '0;
    assign err_addr_o = '0;
`endif

endmodule

// File: tb/tb_picobello_dummy_tile.sv
// Directed self-checking bench for picobello_dummy_tile.
module tb_picobello_dummy_tile;
    import picobello_dummy_tile_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    id_t         id_i;
    logic        aw_valid_i, aw_ready_o;
    logic [3:0]  aw_id_i;
    logic [47:0] aw_addr_i;
    logic        w_valid_i, w_ready_o, w_last_i;
    logic        b_valid_o, b_ready_i;
    logic [3:0]  b_id_o;
    logic [1:0]  b_resp_o;
    logic        ar_valid_i, ar_ready_o;
    logic [3:0]  ar_id_i;
    logic [47:0] ar_addr_i;
    logic [7:0]  ar_len_i;
    logic        r_valid_o, r_ready_i;
    logic [3:0]  r_id_o;
    logic [63:0] r_data_o;
    logic [1:0]  r_resp_o;
    logic        r_last_o;
    logic [31:0] err_cnt_o;
    logic [47:0] err_addr_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    picobello_dummy_tile dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .id_i(id_i),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
        .ar_len_i(ar_len_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
        .r_resp_o(r_resp_o), .r_last_o(r_last_o),
        .err_cnt_o(err_cnt_o), .err_addr_o(err_addr_o)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // Reset asserted at a negedge, held two cycles, released at a negedge.
    task automatic do_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    int beats;

    initial begin
        rst_ni = 1'b0;
        id_i = '{x: 4'd2, y: 4'd1};
        aw_valid_i = 0; aw_id_i = 0; aw_addr_i = 0;
        w_valid_i = 0; w_last_i = 0; b_ready_i = 0;
        ar_valid_i = 0; ar_id_i = 0; ar_addr_i = 0; ar_len_i = 0; r_ready_i = 0;

        // Reset state
        repeat (2) @(negedge clk_i);
        check_val("rst_aw_ready", aw_ready_o, 0);
        check_val("rst_ar_ready", ar_ready_o, 0);
        check_val("rst_w_ready", w_ready_o, 0);
        check_val("rst_b_valid", b_valid_o, 0);
        check_val("rst_r_valid", r_valid_o, 0);
        check_val("rst_ids", {b_id_o, r_id_o}, 0);
        check_val("rst_err_cnt", err_cnt_o, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_val("post_rst_aw_ready", aw_ready_o, 1);
        check_val("post_rst_ar_ready", ar_ready_o, 1);

        // W beats before any AW stall
        w_valid_i = 1; w_last_i = 1;
        repeat (3) begin
            @(negedge clk_i);
            check_val("early_w_ready", w_ready_o, 0);
            check_val("early_b_valid", b_valid_o, 0);
        end

        // Write: id 3, 4 beats
        w_valid_i = 0; w_last_i = 0; b_ready_i = 1;
        aw_valid_i = 1; aw_id_i = 4'd3; aw_addr_i = 48'h0000_2000_0040;
        @(negedge clk_i);
        aw_valid_i = 0;
        check_val("wr_aw_ready_busy", aw_ready_o, 0);
        for (int i = 0; i < 4; i++) begin
            check_val("wr_w_ready", w_ready_o, 1);
            check_val("wr_no_b", b_valid_o, 0);
            w_valid_i = 1; w_last_i = (i == 3);
            @(negedge clk_i);
        end
        w_valid_i = 0; w_last_i = 0;
        check_val("wr_b_valid", b_valid_o, 1);
        check_val("wr_b_id", b_id_o, 3);
        check_val("wr_b_resp", b_resp_o, 2'b11);
        check_val("wr_w_ready_off", w_ready_o, 0);
        @(negedge clk_i);
        check_val("wr_b_one_cycle", b_valid_o, 0);
        check_val("wr_aw_ready_back", aw_ready_o, 1);

        // Read: id 5, len 7
        r_ready_i = 1;
        ar_valid_i = 1; ar_id_i = 4'd5; ar_len_i = 8'd7; ar_addr_i = 48'h1234;
        @(negedge clk_i);
        ar_valid_i = 0;
        for (int i = 0; i < 8; i++) begin
            check_val("rd8_valid", r_valid_o, 1);
            check_val("rd8_id", r_id_o, 5);
            check_val("rd8_data", r_data_o, 0);
            check_val("rd8_resp", r_resp_o, 2'b11);
            check_val("rd8_last", r_last_o, (i == 7));
            @(negedge clk_i);
        end
        check_val("rd8_done", r_valid_o, 0);
        check_val("rd8_ar_ready", ar_ready_o, 1);

        // Read len 0 with r_ready held low then high
        r_ready_i = 0;
        ar_valid_i = 1; ar_id_i = 4'd9; ar_len_i = 8'd0;
        @(negedge clk_i);
        ar_valid_i = 0;
        check_val("rd1_valid", r_valid_o, 1);
        check_val("rd1_last", r_last_o, 1);
        @(negedge clk_i);
        check_val("rd1_hold_valid", r_valid_o, 1);
        check_val("rd1_hold_last", r_last_o, 1);
        check_val("rd1_hold_id", r_id_o, 9);
        check_val("rd1_ar_blocked", ar_ready_o, 0);
        r_ready_i = 1;
        @(negedge clk_i);
        check_val("rd1_done", r_valid_o, 0);

        // Read len 255: exactly 256 beats, last only on the final one
        ar_valid_i = 1; ar_id_i = 4'd7; ar_len_i = 8'd255;
        @(negedge clk_i);
        ar_valid_i = 0;
        beats = 0;
        for (int i = 0; i < 300; i++) begin
            if (!r_valid_o) break;
            beats++;
            if (r_last_o) begin
                @(negedge clk_i);
                break;
            end
            @(negedge clk_i);
        end
        check_val("rd256_beats", beats, 256);
        check_val("rd256_done", r_valid_o, 0);

        // Simultaneous AW and AR from a fresh reset
        do_reset();
        aw_valid_i = 1; aw_id_i = 4'd1; aw_addr_i = 48'h0000_AAAA_0000;
        ar_valid_i = 1; ar_id_i = 4'd2; ar_addr_i = 48'h0000_BBBB_0000; ar_len_i = 8'd1;
        b_ready_i = 1; r_ready_i = 1;
        @(negedge clk_i);
        aw_valid_i = 0; ar_valid_i = 0;
        check_val("dual_w_ready", w_ready_o, 1);
        check_val("dual_r_valid", r_valid_o, 1);
        check_val("dual_r_last0", r_last_o, 0);
`ifdef PB_DUMMY_ERR_LOG_EN
        check_val("dual_err_cnt", err_cnt_o, 2);
        check_val("dual_err_addr", err_addr_o, 48'h0000_AAAA_0000);
`else
        check_val("dual_err_cnt", err_cnt_o, 0);
        check_val("dual_err_addr", err_addr_o, 0);
`endif
        w_valid_i = 1; w_last_i = 1;
        @(negedge clk_i);
        w_valid_i = 0; w_last_i = 0;
        check_val("dual_b_valid", b_valid_o, 1);
        check_val("dual_b_id", b_id_o, 1);
        check_val("dual_r_last1", r_last_o, 1);
        check_val("dual_r_id", r_id_o, 2);
        @(negedge clk_i);
        check_val("dual_b_done", b_valid_o, 0);
        check_val("dual_r_done", r_valid_o, 0);

        // Reset during beat 3 of a len 15 read
        ar_valid_i = 1; ar_id_i = 4'd4; ar_len_i = 8'd15;
        @(negedge clk_i);
        ar_valid_i = 0;
        repeat (3) @(negedge clk_i);
        check_val("mid_r_valid_pre", r_valid_o, 1);
        rst_ni = 1'b0;
        #1;
        check_val("mid_r_valid_rst", r_valid_o, 0);
        check_val("mid_r_id_rst", r_id_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_val("mid_ar_ready", ar_ready_o, 1);
        check_val("mid_no_beat", r_valid_o, 0);
        ar_valid_i = 1; ar_id_i = 4'd6; ar_len_i = 8'd1;
        @(negedge clk_i);
        ar_valid_i = 0;
        check_val("mid_next_b0", {r_valid_o, r_last_o, r_id_o}, {1'b1, 1'b0, 4'd6});
        @(negedge clk_i);
        check_val("mid_next_b1", {r_valid_o, r_last_o, r_id_o}, {1'b1, 1'b1, 4'd6});
        @(negedge clk_i);
        check_val("mid_next_done", r_valid_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
